// File: rtl/umi_mem_arbiter.sv
// Round-robin share of one SUMI device port among N hosts, with responses routed back by in-order tags.
// Zero-latency request pass-through; a stalled grant is locked until its handshake; a full tag FIFO blocks response-bearing requests.
module umi_mem_arbiter #(
  parameter int N     = 2,
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 256,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic [N-1:0]            host_req_valid,
  input  logic [N*CW-1:0]         host_req_cmd,
  input  logic [N*AW-1:0]         host_req_dstaddr,
  input  logic [N*AW-1:0]         host_req_srcaddr,
  input  logic [N*DW-1:0]         host_req_data,
  output logic [N-1:0]            host_req_ready,
  output logic [N-1:0]            host_resp_valid,
  output logic [N*CW-1:0]         host_resp_cmd,
  output logic [N*AW-1:0]         host_resp_dstaddr,
  output logic [N*AW-1:0]         host_resp_srcaddr,
  output logic [N*DW-1:0]         host_resp_data,
  input  logic [N-1:0]            host_resp_ready,
  output logic                    dev_req_valid,
  output logic [CW-1:0]           dev_req_cmd,
  output logic [AW-1:0]           dev_req_dstaddr,
  output logic [AW-1:0]           dev_req_srcaddr,
  output logic [DW-1:0]           dev_req_data,
  input  logic                    dev_req_ready,
  input  logic                    dev_resp_valid,
  input  logic [CW-1:0]           dev_resp_cmd,
  input  logic [AW-1:0]           dev_resp_dstaddr,
  input  logic [AW-1:0]           dev_resp_srcaddr,
  input  logic [DW-1:0]           dev_resp_data,
  output logic                    dev_resp_ready,
  output logic [$clog2(DEPTH):0]  outstanding
);

  localparam int TW   = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [TW-1:0]   rr_q, rr_d, grant_q, grant_d, rr_pick, g, head;
  logic            lock_q, lock_d;
  logic [TW-1:0]   tag_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    elig;
  logic            any_elig, full, empty, hs, push, pop;
  int              idx;

  assign full  = (cnt_q == CNTW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Posted writes (opcode 0x05) never need a tag, so they bypass the full check.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = host_req_valid[i] &
                ((host_req_cmd[i*CW +: 5] == 5'h05) | !full);
    end
  end

  always_comb begin
    any_elig = 1'b0;
    rr_pick  = '0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_q) + k) % N;
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        rr_pick  = TW'(idx);
      end
    end
  end

  assign g               = lock_q ? grant_q : rr_pick;
  assign dev_req_valid   = nreset & (any_elig | lock_q);
  assign dev_req_cmd     = host_req_cmd[int'(g)*CW +: CW];
  assign dev_req_dstaddr = host_req_dstaddr[int'(g)*AW +: AW];
  assign dev_req_srcaddr = host_req_srcaddr[int'(g)*AW +: AW];
  assign dev_req_data    = host_req_data[int'(g)*DW +: DW];
  assign hs              = dev_req_valid & dev_req_ready;
  assign push            = hs & (dev_req_cmd[4:0] != 5'h05);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      host_req_ready[i] = hs & (g == TW'(i));
    end
  end

  assign head           = tag_q[rd_q];
  assign dev_resp_ready = nreset & !empty & host_resp_ready[head];
  assign pop            = dev_resp_valid & dev_resp_ready;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      host_resp_valid[i] = nreset & dev_resp_valid & !empty & (head == TW'(i));
    end
  end

  assign host_resp_cmd     = {N{dev_resp_cmd}};
  assign host_resp_dstaddr = {N{dev_resp_dstaddr}};
  assign host_resp_srcaddr = {N{dev_resp_srcaddr}};
  assign host_resp_data    = {N{dev_resp_data}};

  always_comb begin
    rr_d    = rr_q;
    lock_d  = lock_q;
    grant_d = grant_q;
    if (hs) begin
      rr_d   = (g == TW'(N-1)) ? '0 : g + TW'(1);
      lock_d = 1'b0;
    end else if (dev_req_valid) begin
      lock_d  = 1'b1;
      grant_d = g;
    end
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    rd_d  = pop  ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CNTW'(push) - CNTW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      rr_q    <= '0;
      lock_q  <= 1'b0;
      grant_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_q[wr_q] <= g;
  end

  assign outstanding = cnt_q;

endmodule

// File: tb/tb_umi_mem_arbiter.sv
// Directed bench for umi_mem_arbiter (N=2, DEPTH=4): arbitration table plus tag-routing sequences.
module tb_umi_mem_arbiter;
  localparam int N = 2, CW = 32, AW = 64, DW = 256, DEPTH = 4;

  logic              clk, nreset;
  logic [N-1:0]      host_req_valid, host_req_ready, host_resp_valid, host_resp_ready;
  logic [N*CW-1:0]   host_req_cmd, host_resp_cmd;
  logic [N*AW-1:0]   host_req_dstaddr, host_req_srcaddr, host_resp_dstaddr, host_resp_srcaddr;
  logic [N*DW-1:0]   host_req_data, host_resp_data;
  logic              dev_req_valid, dev_req_ready, dev_resp_valid, dev_resp_ready;
  logic [CW-1:0]     dev_req_cmd, dev_resp_cmd;
  logic [AW-1:0]     dev_req_dstaddr, dev_req_srcaddr, dev_resp_dstaddr, dev_resp_srcaddr;
  logic [DW-1:0]     dev_req_data, dev_resp_data;
  logic [$clog2(DEPTH):0] outstanding;

  int checks = 0;
  int errors = 0;

  umi_mem_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .nreset(nreset),
    .host_req_valid(host_req_valid), .host_req_cmd(host_req_cmd),
    .host_req_dstaddr(host_req_dstaddr), .host_req_srcaddr(host_req_srcaddr),
    .host_req_data(host_req_data), .host_req_ready(host_req_ready),
    .host_resp_valid(host_resp_valid), .host_resp_cmd(host_resp_cmd),
    .host_resp_dstaddr(host_resp_dstaddr), .host_resp_srcaddr(host_resp_srcaddr),
    .host_resp_data(host_resp_data), .host_resp_ready(host_resp_ready),
    .dev_req_valid(dev_req_valid), .dev_req_cmd(dev_req_cmd),
    .dev_req_dstaddr(dev_req_dstaddr), .dev_req_srcaddr(dev_req_srcaddr),
    .dev_req_data(dev_req_data), .dev_req_ready(dev_req_ready),
    .dev_resp_valid(dev_resp_valid), .dev_resp_cmd(dev_resp_cmd),
    .dev_resp_dstaddr(dev_resp_dstaddr), .dev_resp_srcaddr(dev_resp_srcaddr),
    .dev_resp_data(dev_resp_data), .dev_resp_ready(dev_resp_ready),
    .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] vld;
    logic       rdy;
    logic       exp_dvld;
    logic [1:0] exp_hrdy;
    int         exp_g;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] cmd, input logic [63:0] addr);
    host_req_cmd[p*CW +: CW]     = cmd;
    host_req_dstaddr[p*AW +: AW] = addr;
    host_req_srcaddr[p*AW +: AW] = addr + 64'h8000;
    host_req_data[p*DW +: DW]    = {4{addr}};
  endtask

  task automatic chk_all_idle(input string tag);
    chk({tag, "_dev_req_valid"}, 256'(dev_req_valid), 256'd0);
    chk({tag, "_host_req_ready"}, 256'(host_req_ready), 256'd0);
    chk({tag, "_dev_resp_ready"}, 256'(dev_resp_ready), 256'd0);
    chk({tag, "_host_resp_valid"}, 256'(host_resp_valid), 256'd0);
  endtask

  initial begin
    // Posted writes keep the tag FIFO out of the arbitration table.
    vecs[0] = '{2'b11, 1'b1, 1'b1, 2'b01, 0};
    vecs[1] = '{2'b11, 1'b1, 1'b1, 2'b10, 1};
    vecs[2] = '{2'b11, 1'b1, 1'b1, 2'b01, 0};
    vecs[3] = '{2'b11, 1'b1, 1'b1, 2'b10, 1};
    vecs[4] = '{2'b10, 1'b1, 1'b1, 2'b10, 1};
    vecs[5] = '{2'b00, 1'b1, 1'b0, 2'b00, 0};
    vecs[6] = '{2'b10, 1'b0, 1'b1, 2'b00, 1};
    vecs[7] = '{2'b11, 1'b0, 1'b1, 2'b00, 1};
    vecs[8] = '{2'b11, 1'b1, 1'b1, 2'b10, 1};
    vecs[9] = '{2'b11, 1'b1, 1'b1, 2'b01, 0};

    nreset = 1'b0;
    host_req_valid = 2'b11; host_req_cmd = '0; host_req_dstaddr = '0;
    host_req_srcaddr = '0; host_req_data = '0; host_resp_ready = 2'b11;
    dev_req_ready = 1'b1; dev_resp_valid = 1'b1; dev_resp_cmd = 32'h2;
    dev_resp_dstaddr = 64'h55; dev_resp_srcaddr = 64'h66; dev_resp_data = 256'hABCD;
    set_port(0, 32'h05, 64'h1000);
    set_port(1, 32'h05, 64'h1001);
    tick();
    chk_all_idle("reset");
    tick();
    chk("reset_outstanding", 256'(outstanding), 256'd0);
    nreset = 1'b1; host_req_valid = 2'b00; dev_resp_valid = 1'b0;
    #1;

    // Arbitration table
    for (int i = 0; i < 10; i++) begin
      host_req_valid = vecs[i].vld;
      dev_req_ready  = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_dev_req_valid", i), 256'(dev_req_valid), 256'(vecs[i].exp_dvld));
      chk($sformatf("vec%0d_host_req_ready", i), 256'(host_req_ready), 256'(vecs[i].exp_hrdy));
      if (vecs[i].exp_dvld)
        chk($sformatf("vec%0d_grant", i), 256'(dev_req_dstaddr), 256'(64'h1000 + 64'(vecs[i].exp_g)));
      tick();
    end
    host_req_valid = 2'b00; dev_req_ready = 1'b1;

    // Lock held for 5 stalled cycles, rr pointer is at port 1
    host_req_valid = 2'b11; dev_req_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("lock%0d_dstaddr", c), 256'(dev_req_dstaddr), 256'(64'h1001));
      chk($sformatf("lock%0d_data", c), 256'(dev_req_data), {4{64'h1001}});
      chk($sformatf("lock%0d_ready", c), 256'(host_req_ready), 256'd0);
      tick();
    end
    dev_req_ready = 1'b1;
    #1;
    chk("lock_release_ready", 256'(host_req_ready), 256'(2'b10));
    tick();
    chk("lock_next_grant", 256'(dev_req_dstaddr), 256'(64'h1000));
    tick();
    host_req_valid = 2'b00;

    // Single read from port 0, response 3 cycles later
    set_port(0, 32'h01, 64'h100);
    host_req_valid = 2'b01;
    #1;
    chk("rd_ready", 256'(host_req_ready), 256'(2'b01));
    chk("rd_dstaddr", 256'(dev_req_dstaddr), 256'(64'h100));
    chk("rd_srcaddr", 256'(dev_req_srcaddr), 256'(64'h8100));
    tick();
    host_req_valid = 2'b00;
    chk("rd_outstanding1", 256'(outstanding), 256'd1);
    tick(); tick(); tick();
    chk("rd_outstanding_hold", 256'(outstanding), 256'd1);
    dev_resp_valid = 1'b1; dev_resp_data = 256'hDEAD_BEEF;
    #1;
    chk("rd_host_resp_valid", 256'(host_resp_valid), 256'(2'b01));
    chk("rd_dev_resp_ready", 256'(dev_resp_ready), 256'd1);
    chk("rd_resp_data0", host_resp_data[0 +: DW], 256'hDEAD_BEEF);
    chk("rd_resp_data1", host_resp_data[DW +: DW], 256'hDEAD_BEEF);
    chk("rd_resp_cmd1", 256'(host_resp_cmd[CW +: CW]), 256'(32'h2));
    tick();
    dev_resp_valid = 1'b0;
    chk("rd_outstanding0", 256'(outstanding), 256'd0);

    // Fill the FIFO with 4 port-0 reads, then posted write from port 1
    set_port(0, 32'h01, 64'h200);
    host_req_valid = 2'b01;
    for (int c = 0; c < 4; c++) tick();
    chk("full_outstanding4", 256'(outstanding), 256'd4);
    host_req_valid = 2'b11;
    #1;
    chk("full_post_valid", 256'(dev_req_valid), 256'd1);
    chk("full_post_grant", 256'(dev_req_dstaddr), 256'(64'h1001));
    chk("full_post_ready", 256'(host_req_ready), 256'(2'b10));
    tick();
    chk("full_post_outstanding", 256'(outstanding), 256'd4);
    host_req_valid = 2'b01;
    #1;
    chk("full_block_valid", 256'(dev_req_valid), 256'd0);
    chk("full_block_ready", 256'(host_req_ready), 256'd0);
    tick();
    dev_resp_valid = 1'b1;
    #1;
    chk("full_pop_resp_valid", 256'(host_resp_valid), 256'(2'b01));
    chk("full_pop_no_push", 256'(host_req_ready), 256'd0);
    tick();
    dev_resp_valid = 1'b0;
    chk("full_after_pop", 256'(outstanding), 256'd3);
    #1;
    chk("full_admit_ready", 256'(host_req_ready), 256'(2'b01));
    tick();
    host_req_valid = 2'b00;
    chk("full_refill", 256'(outstanding), 256'd4);
    dev_resp_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("drain%0d_valid", c), 256'(host_resp_valid), 256'(2'b01));
      tick();
    end
    dev_resp_valid = 1'b0;
    chk("drain_outstanding", 256'(outstanding), 256'd0);

    // In-order routing: reads from ports 0,1,0 answered A,B,C
    set_port(0, 32'h01, 64'h300);
    set_port(1, 32'h01, 64'h310);
    host_req_valid = 2'b01; tick();
    host_req_valid = 2'b10; tick();
    host_req_valid = 2'b01; tick();
    host_req_valid = 2'b00;
    chk("ord_outstanding3", 256'(outstanding), 256'd3);
    dev_resp_valid = 1'b1; dev_resp_data = 256'hA;
    #1;
    chk("ord_A_valid", 256'(host_resp_valid), 256'(2'b01));
    chk("ord_A_ready", 256'(dev_resp_ready), 256'd1);
    tick();
    dev_resp_data = 256'hB; host_resp_ready = 2'b01;
    #1;
    chk("ord_B_valid", 256'(host_resp_valid), 256'(2'b10));
    chk("ord_B_stall1", 256'(dev_resp_ready), 256'd0);
    tick();
    #1;
    chk("ord_B_stall2", 256'(dev_resp_ready), 256'd0);
    tick();
    chk("ord_B_held", 256'(outstanding), 256'd2);
    host_resp_ready = 2'b11;
    #1;
    chk("ord_B_ready", 256'(dev_resp_ready), 256'd1);
    chk("ord_B_valid2", 256'(host_resp_valid), 256'(2'b10));
    tick();
    dev_resp_data = 256'hC;
    #1;
    chk("ord_C_valid", 256'(host_resp_valid), 256'(2'b01));
    tick();
    dev_resp_valid = 1'b0;
    chk("ord_outstanding0", 256'(outstanding), 256'd0);

    // Reset with 2 outstanding, then a stray response
    host_req_valid = 2'b01; tick(); tick();
    host_req_valid = 2'b00;
    chk("rst_outstanding2", 256'(outstanding), 256'd2);
    nreset = 1'b0; host_req_valid = 2'b11; dev_resp_valid = 1'b1;
    #1;
    chk_all_idle("midrst");
    tick();
    chk("midrst_outstanding", 256'(outstanding), 256'd0);
    nreset = 1'b1; host_req_valid = 2'b00;
    #1;
    chk("stray_dev_resp_ready", 256'(dev_resp_ready), 256'd0);
    chk("stray_host_resp_valid", 256'(host_resp_valid), 256'd0);
    tick();
    chk("stray_outstanding", 256'(outstanding), 256'd0);
    dev_resp_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
